// File: rtl/serial_add_ctrl_pkg.sv
// Shared state encoding and counter sizing for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width is max(1, ceil(log2 N)) so N=1 still has a real register.
    function automatic int countWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and serial_add_ctrl.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

`ifdef SERIAL_ADD_SUB_EN
    logic         sub;

    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single combinational full-adder cell shared across all operand bits.
module fa_bit (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_bit, LSB first, result N+1 cycles after start.
// SERIAL_ADD_SUB_EN adds a subtract mode (B inverted, carry forced to 1).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = countWidth(N);

    state_t        state_q, state_d;
    logic [N-1:0]  aShift_q, aShift_d;
    logic [N-1:0]  bShift_q, bShift_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] count_q, count_d;
    logic          faSum, faCarry;

    fa_bit uFaBit (
        .s   (faSum),
        .c   (faCarry),
        .a   (aShift_q[0]),
        .b   (bShift_q[0]),
        .cin (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    aShift_d = bus.a;
                    bShift_d = bus.b;
                    carry_d  = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
                    if (bus.sub) begin
                        bShift_d = ~bus.b;
                        carry_d  = 1'b1;
                    end
`endif
                    count_d  = '0;
                    sum_d    = '0;
                end
            end
            RUN: begin
                // Each sum bit enters at the MSB so after N shifts bit 0 lands in place.
                sum_d        = sum_q >> 1;
                sum_d[N-1]   = faSum;
                aShift_d     = aShift_q >> 1;
                bShift_d     = bShift_q >> 1;
                carry_d      = faCarry;
                count_d      = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = faCarry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: timeline reference model plus directed and random operations.
module tb_serial_add_ctrl;

    localparam int N = 4;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic subDrv = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.N(N)) bus ();

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = subDrv;
`endif

    serial_add_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Reference model: cycles left until idle, and the arithmetic result once presented.
    int           rem     = 0;
    logic [N:0]   pend    = '0;
    logic [N-1:0] expSum  = '0;
    logic         expCout = 1'b0;

    function automatic logic [N:0] refResult(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic cin, input logic sub);
        if (sub)
            return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rem     = 0;
            expSum  = '0;
            expCout = 1'b0;
        end else if (rem == 0) begin
            if (bus.start) begin
                rem  = N + 1;
                pend = refResult(bus.a, bus.b, bus.cin, SUB_EN && subDrv);
            end
        end else begin
            rem = rem - 1;
            if (rem == 1)
                {expCout, expSum} = pend;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 64'(bus.busy), 64'(rem > 0));
            checkOutput("done", 64'(bus.done), 64'(rem == 1));
            if (rem <= 1) begin
                checkOutput("sum", 64'(bus.sum), 64'(expSum));
                checkOutput("cout", 64'(bus.cout), 64'(expCout));
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        subDrv    = sub;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.cin   = 1'($urandom);
        subDrv    = SUB_EN ? 1'($urandom) : 1'b0;
    endtask

    // Entered on the falling edge right after the accepting edge (cycle 1).
    task automatic waitDone(input string name, input logic [N-1:0] es, input logic ec, input int expLat);
        int cyc = 1;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end else begin
            checkOutput({name, "_sum"}, 64'(bus.sum), 64'(es));
            checkOutput({name, "_cout"}, 64'(bus.cout), 64'(ec));
            if (expLat > 0)
                checkOutput({name, "_latency"}, 64'(cyc), 64'(expLat));
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nDone;
        int doneAt[$];
        logic [N-1:0] ra, rb;
        logic rc, rs;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_sum", 64'(bus.sum), 64'd0);
        checkOutput("rst_cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;

        $display("[TB] zero operands, latency");
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);
        waitDone("zero", 4'd0, 1'b0, 5);
        @(negedge clk);
        checkOutput("zero_idle_busy", 64'(bus.busy), 64'd0);

        $display("[TB] carry-in and wrap");
        applyStimulus(4'd1, 4'd1, 1'b1, 1'b0);
        waitDone("cin", 4'd3, 1'b0, 5);
        applyStimulus(4'd15, 4'd1, 1'b0, 1'b0);
        waitDone("wrap", 4'd0, 1'b1, 5);

        $display("[TB] start while busy is ignored");
        applyStimulus(4'd5, 4'd6, 1'b0, 1'b0);
        bus.a = 4'd15;
        bus.b = 4'd15;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("ignore", 4'd11, 1'b0, 0);
        countDones(10, nDone);
        checkOutput("ignore_extra_done", 64'(nDone), 64'd0);

        $display("[TB] reset during RUN");
        applyStimulus(4'd9, 4'd4, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_sum", 64'(bus.sum), 64'd0);
        checkOutput("abort_cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;
        countDones(10, nDone);
        checkOutput("abort_no_done", 64'(nDone), 64'd0);
        applyStimulus(4'd2, 4'd3, 1'b0, 1'b0);
        waitDone("after_abort", 4'd5, 1'b0, 5);

        $display("[TB] start held high");
        @(negedge clk);
        bus.a = 4'd7;
        bus.b = 4'd9;
        bus.cin = 1'b0;
        subDrv = 1'b0;
        bus.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                doneAt.push_back(i);
                checkOutput("held_sum", 64'(bus.sum), 64'd0);
                checkOutput("held_cout", 64'(bus.cout), 64'd1);
            end
        end
        bus.start = 1'b0;
        checkOutput("held_pulses", 64'(doneAt.size()), 64'd5);
        for (int i = 1; i < doneAt.size(); i++)
            checkOutput("held_spacing", 64'(doneAt[i] - doneAt[i-1]), 64'd6);
        repeat (10) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtract mode");
        applyStimulus(4'd5, 4'd3, 1'b0, 1'b1);
        waitDone("sub_pos", 4'd2, 1'b1, 5);
        applyStimulus(4'd3, 4'd5, 1'b1, 1'b1);
        waitDone("sub_neg", 4'd14, 1'b0, 5);
        applyStimulus(4'd3, 4'd5, 1'b1, 1'b0);
        waitDone("sub_off", 4'd9, 1'b0, 5);
`endif

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            applyStimulus(ra, rb, rc, rs);
            case ($urandom_range(0, 9))
                0: begin
                    repeat ($urandom_range(0, N)) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (3) @(negedge clk);
                end
                1, 2, 3: begin
                    repeat ($urandom_range(0, N - 2)) @(negedge clk);
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.start = 1'b0;
                    {rc, ra} = refResult(ra, rb, rc, rs);
                    waitDone("rand_intr", ra, rc, 0);
                end
                default: begin
                    {rc, ra} = refResult(ra, rb, rc, rs);
                    waitDone("rand", ra, rc, 5);
                end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
